end_screen_sequencer: RTL



---
 rtl/end_screen_pkg.sv | 25 ++
 rtl/frame_tick_counter.sv | 41 ++++
 rtl/end_screen_sequencer.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/end_screen_pkg.sv
// Shared types and constants for the game-over screen sequencer.
// Holds the state encoding, frame-counter width and the slide clamp helper.
package end_screen_pkg;

  localparam int FRAME_CNT_W = 8;

  typedef logic [10:0] coord_t;

  typedef enum logic [2:0] {
    ST_PLAY    = 3'd0,
    ST_FREEZE  = 3'd1,
    ST_SLIDE   = 3'd2,
    ST_BLINK   = 3'd3,
    ST_RESTART = 3'd4
  } state_e;

  // One slide step, summed in 12 bits so a large step cannot wrap past the target.
  function automatic coord_t slide_next(input coord_t y, input coord_t step, input coord_t target);
    logic [11:0] sum;
    sum = {1'b0, y} + {1'b0, step};
    if (sum >= {1'b0, target}) return target;
    return sum[10:0];
  endfunction

endpackage

// File: rtl/frame_tick_counter.sv
// Counts startOfFrame ticks with a synchronous clear.
// Wrap mode: hit_o flags the tick that completes limit_i frames. Saturate mode: hit_o is high once the count reaches limit_i.
module frame_tick_counter
  import end_screen_pkg::*;
#(
  parameter bit SATURATE = 1'b0
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   clr_i,
  input  logic                   en_i,
  input  logic [FRAME_CNT_W-1:0] limit_i,
  output logic                   hit_o
);

  logic [FRAME_CNT_W-1:0] cnt_q, cnt_d;
  logic                   at_last;

  assign at_last = (cnt_q == limit_i - FRAME_CNT_W'(1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      if (SATURATE) begin
        if (cnt_q != limit_i) cnt_d = cnt_q + FRAME_CNT_W'(1);
      end else begin
        cnt_d = at_last ? '0 : cnt_q + FRAME_CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign hit_o = SATURATE ? (cnt_q == limit_i) : (en_i && at_last);

endmodule

// File: rtl/end_screen_sequencer.sv
// Game-over screen sequencer: freeze play, slide the GAME OVER bitmap down,
// blink it, then wait for a fresh restart key press and strobe restartPulse.
module end_screen_sequencer
  import end_screen_pkg::*;
#(
  parameter int unsigned END_X             = 304,
  parameter int unsigned START_Y           = 0,
  parameter int unsigned TARGET_Y          = 224,
  parameter int unsigned SLIDE_STEP        = 4,
  parameter int unsigned FREEZE_FRAMES     = 60,
  parameter int unsigned BLINK_HALF_FRAMES = 16,
  parameter int unsigned MIN_SHOW_FRAMES   = 120
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        startOfFrame,
  input  logic [2:0]  lives,
  input  logic        restartKey,
  output logic        endEnable,
  output logic [10:0] topLeftX,
  output logic [10:0] topLeftY,
  output logic        freezeGame,
  output logic        restartPulse,
  output logic [2:0]  state
);

  localparam coord_t END_X_C    = coord_t'(END_X);
  localparam coord_t START_Y_C  = coord_t'(START_Y);
  localparam coord_t TARGET_Y_C = coord_t'(TARGET_Y);
  localparam coord_t STEP_C     = coord_t'(SLIDE_STEP);
  localparam logic [FRAME_CNT_W-1:0] FREEZE_LIM = FRAME_CNT_W'(FREEZE_FRAMES);
  localparam logic [FRAME_CNT_W-1:0] BLINK_LIM  = FRAME_CNT_W'(BLINK_HALF_FRAMES);
  localparam logic [FRAME_CNT_W-1:0] SHOW_LIM   = FRAME_CNT_W'(MIN_SHOW_FRAMES);

  state_e state_q, state_d;
  logic   end_q, end_d;
  coord_t y_q, y_d;
  logic   freeze_q, freeze_d;
  logic   pulse_q, pulse_d;
  logic   key_prev_q;

  logic   cnt_clr, in_blink, blink_en;
  logic   frame_hit, blink_hit, show_hit;
  logic   key_rise;

  // All counters restart on any state change so each state sees a fresh count.
  assign cnt_clr  = (state_d != state_q);
  assign in_blink = (state_q == ST_BLINK);
  assign blink_en = startOfFrame && in_blink;
  assign key_rise = restartKey && !key_prev_q;

  frame_tick_counter #(.SATURATE(1'b0)) u_frame_cnt (
    .clk_i   (clk),
    .rst_i   (reset),
    .clr_i   (cnt_clr),
    .en_i    (startOfFrame),
    .limit_i (FREEZE_LIM),
    .hit_o   (frame_hit)
  );

  frame_tick_counter #(.SATURATE(1'b0)) u_blink_cnt (
    .clk_i   (clk),
    .rst_i   (reset),
    .clr_i   (cnt_clr),
    .en_i    (blink_en),
    .limit_i (BLINK_LIM),
    .hit_o   (blink_hit)
  );

  frame_tick_counter #(.SATURATE(1'b1)) u_show_cnt (
    .clk_i   (clk),
    .rst_i   (reset),
    .clr_i   (cnt_clr),
    .en_i    (blink_en),
    .limit_i (SHOW_LIM),
    .hit_o   (show_hit)
  );

  always_comb begin
    state_d  = state_q;
    end_d    = end_q;
    y_d      = y_q;
    freeze_d = freeze_q;
    pulse_d  = 1'b0;
    case (state_q)
      ST_PLAY: begin
        end_d    = 1'b0;
        y_d      = START_Y_C;
        freeze_d = 1'b0;
        if (lives == 3'b000) begin
          state_d  = ST_FREEZE;
          freeze_d = 1'b1;
        end
      end
      ST_FREEZE: begin
        freeze_d = 1'b1;
        end_d    = 1'b0;
        if (frame_hit) begin
          state_d = ST_SLIDE;
          end_d   = 1'b1;
          y_d     = START_Y_C;
        end
      end
      ST_SLIDE: begin
        freeze_d = 1'b1;
        end_d    = 1'b1;
        if (startOfFrame) begin
          y_d = slide_next(y_q, STEP_C, TARGET_Y_C);
          if (y_d == TARGET_Y_C) state_d = ST_BLINK;
        end
      end
      ST_BLINK: begin
        freeze_d = 1'b1;
        y_d      = TARGET_Y_C;
        // A restart on a toggle frame wins; the bitmap goes dark with the pulse.
        if (show_hit && key_rise) begin
          state_d = ST_RESTART;
          pulse_d = 1'b1;
          end_d   = 1'b0;
        end else if (blink_hit) begin
          end_d = !end_q;
        end
      end
      ST_RESTART: begin
        state_d  = ST_PLAY;
        end_d    = 1'b0;
        y_d      = START_Y_C;
        freeze_d = 1'b0;
      end
      default: begin
        state_d  = ST_PLAY;
        end_d    = 1'b0;
        y_d      = START_Y_C;
        freeze_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_PLAY;
      end_q      <= 1'b0;
      y_q        <= START_Y_C;
      freeze_q   <= 1'b0;
      pulse_q    <= 1'b0;
      key_prev_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      end_q      <= end_d;
      y_q        <= y_d;
      freeze_q   <= freeze_d;
      pulse_q    <= pulse_d;
      key_prev_q <= restartKey;
    end
  end

  assign endEnable    = end_q;
  assign topLeftX     = END_X_C;
  assign topLeftY     = y_q;
  assign freezeGame   = freeze_q;
  assign restartPulse = pulse_q;
  assign state        = state_q;

endmodule
